// File: rtl/wb_cmd_master.sv
// Single-transaction classic Wishbone initiator driven by a command/response
// handshake; every bus cycle is bounded by a TIMEOUT-cycle strobe limit.
module wb_cmd_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_dat,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    input  logic        wb_ack_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [15:0] cnt;

    assign cmd_ready = (state == IDLE);
    assign wb_stb_o  = wb_cyc_o;
    assign wb_sel_o  = 4'hF;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wb_cyc_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_dat   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        wb_adr_o <= cmd_adr;
                        wb_dat_o <= cmd_dat;
                        wb_we_o  <= cmd_we;
                        wb_cyc_o <= 1'b1;
                        cnt      <= '0;
                        state    <= BUS;
                    end
                end
                BUS: begin
                    // Ack is checked first so a last-cycle ack still succeeds
                    if (wb_ack_i) begin
                        wb_cyc_o  <= 1'b0;
                        rsp_dat   <= wb_we_o ? 32'h0 : wb_dat_i;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (cnt == LAST) begin
                        wb_cyc_o  <= 1'b0;
                        rsp_dat   <= 32'h0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    wb_cyc_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed self-checking bench for wb_cmd_master with a wait-state
// programmable slave model.
module tb_wb_cmd_master;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_dat;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic        wb_ack_i;

    wb_cmd_master #(.TIMEOUT(8)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_dat   (rsp_dat),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_sel_o  (wb_sel_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_ack_i  (wb_ack_i)
    );

    always #5 sys_clk = ~sys_clk;

    // Slave: acks in the stb cycle numbered slave_wait (0 = first cycle)
    logic [7:0]  stb_cnt = '0;
    logic [7:0]  slave_wait = '0;
    logic [31:0] slave_data = '0;

    always @(posedge sys_clk) begin
        if (wb_stb_o) stb_cnt <= stb_cnt + 8'd1;
        else          stb_cnt <= '0;
    end

    assign wb_ack_i = wb_stb_o && (stb_cnt == slave_wait);
    assign wb_dat_i = wb_ack_i ? slave_data : 32'h0;

    int n_cmp = 0;
    int n_err = 0;

    int          res_cyc;
    logic        res_done;
    logic        res_err;
    logic [31:0] res_dat;
    logic        res_ready_after;
    logic        res_valid_after;
    logic        cap_we;
    logic [31:0] cap_dat;
    logic [31:0] cap_adr;
    logic        stb_bad;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic we, input logic [31:0] adr,
                           input logic [31:0] dat);
        logic first;
        @(negedge sys_clk);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        @(posedge sys_clk);
        #1 cmd_valid = 1'b0;
        res_cyc  = 0;
        res_done = 1'b0;
        res_err  = 1'bx;
        res_dat  = 'x;
        stb_bad  = 1'b0;
        first    = 1'b1;
        for (int i = 0; i < 40 && !res_done; i++) begin
            @(negedge sys_clk);
            if (wb_stb_o !== wb_cyc_o) stb_bad = 1'b1;
            if (wb_cyc_o) begin
                if (first) begin
                    cap_we  = wb_we_o;
                    cap_dat = wb_dat_o;
                    cap_adr = wb_adr_o;
                    first   = 1'b0;
                end
                res_cyc++;
            end
            if (rsp_valid) begin
                res_done = 1'b1;
                res_err  = rsp_err;
                res_dat  = rsp_dat;
            end
        end
        chk("rsp_seen", 32'(res_done), 32'd1);
        @(negedge sys_clk);
        res_ready_after = cmd_ready;
        res_valid_after = rsp_valid;
    endtask

    logic [5:0] cyc_pat;
    logic [5:0] vld_pat;
    logic [5:0] rdy_pat;
    logic [31:0] b2b_d0;
    logic [31:0] b2b_d1;
    logic        seen_vld;

    initial begin
        // Reset values
        #23;
        chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_we", 32'(wb_we_o), 32'd0);
        chk("rst_adr", wb_adr_o, 32'h0);
        chk("rst_dat", wb_dat_o, 32'h0);
        chk("rst_vld", 32'(rsp_valid), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_rdat", rsp_dat, 32'h0);
        chk("rst_sel", 32'(wb_sel_o), 32'hF);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);

        // Zero-wait write
        slave_wait = 8'd0;
        slave_data = 32'hCAFE0000;
        run_cmd(1'b1, 32'h6000_0000, 32'h0000_0001);
        chk("zw_we", 32'(cap_we), 32'd1);
        chk("zw_dat", cap_dat, 32'h1);
        chk("zw_adr", cap_adr, 32'h6000_0000);
        chk("zw_cyc_len", 32'(res_cyc), 32'd1);
        chk("zw_err", 32'(res_err), 32'd0);
        chk("zw_rdat", res_dat, 32'h0);
        chk("zw_ready", 32'(res_ready_after), 32'd1);
        chk("zw_single", 32'(res_valid_after), 32'd0);
        chk("zw_stb_eq", 32'(stb_bad), 32'd0);

        // Three wait states read
        slave_wait = 8'd3;
        slave_data = 32'hDEADBEEF;
        run_cmd(1'b0, 32'h0000_0100, 32'h5555_5555);
        chk("w3_we", 32'(cap_we), 32'd0);
        chk("w3_cyc_len", 32'(res_cyc), 32'd4);
        chk("w3_err", 32'(res_err), 32'd0);
        chk("w3_rdat", res_dat, 32'hDEADBEEF);
        chk("w3_single", 32'(res_valid_after), 32'd0);
        chk("w3_ready", 32'(res_ready_after), 32'd1);

        // Timeout, slave never acks
        slave_wait = 8'd200;
        slave_data = 32'hFFFF_FFFF;
        run_cmd(1'b0, 32'h0000_0200, 32'h0);
        chk("to_cyc_len", 32'(res_cyc), 32'd8);
        chk("to_err", 32'(res_err), 32'd1);
        chk("to_rdat", res_dat, 32'h0);
        chk("to_ready", 32'(res_ready_after), 32'd1);
        chk("to_stb_eq", 32'(stb_bad), 32'd0);

        // Ack in the last allowed cycle
        slave_wait = 8'd7;
        slave_data = 32'h1234_5678;
        run_cmd(1'b0, 32'h0000_0300, 32'h0);
        chk("last_cyc_len", 32'(res_cyc), 32'd8);
        chk("last_err", 32'(res_err), 32'd0);
        chk("last_rdat", res_dat, 32'h1234_5678);

        // Back-to-back: write then read with cmd_valid held high
        slave_wait = 8'd0;
        slave_data = 32'h55AA_0011;
        @(negedge sys_clk);
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h0000_0010;
        cmd_dat   = 32'h0000_000A;
        cyc_pat = '0;
        vld_pat = '0;
        rdy_pat = '0;
        b2b_d0  = 'x;
        b2b_d1  = 'x;
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clk);
            cyc_pat[5-i] = wb_cyc_o;
            vld_pat[5-i] = rsp_valid;
            rdy_pat[5-i] = cmd_ready;
            if (i == 1) begin
                b2b_d0 = rsp_dat;
                cmd_we = 1'b0;
                cmd_adr = 32'h0000_0014;
            end
            if (i == 3) cmd_valid = 1'b0;
            if (i == 4) b2b_d1 = rsp_dat;
        end
        chk("b2b_cyc", 32'(cyc_pat), 32'b100100);
        chk("b2b_vld", 32'(vld_pat), 32'b010010);
        chk("b2b_rdy", 32'(rdy_pat), 32'b001001);
        chk("b2b_wr_rdat", b2b_d0, 32'h0);
        chk("b2b_rd_rdat", b2b_d1, 32'h55AA_0011);

        // Asynchronous reset during the second stb cycle
        slave_wait = 8'd200;
        @(negedge sys_clk);
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h0000_0400;
        cmd_dat   = 32'h0000_0077;
        @(posedge sys_clk);
        #1 cmd_valid = 1'b0;
        @(posedge sys_clk);
        #2;
        chk("ar_cyc_before", 32'(wb_cyc_o), 32'd1);
        sys_rst = 1'b1;
        #1;
        chk("ar_cyc_async", 32'(wb_cyc_o), 32'd0);
        chk("ar_stb_async", 32'(wb_stb_o), 32'd0);
        seen_vld = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            if (rsp_valid) seen_vld = 1'b1;
        end
        chk("ar_no_rsp", 32'(seen_vld), 32'd0);
        chk("ar_ready", 32'(cmd_ready), 32'd1);
        slave_wait = 8'd0;
        run_cmd(1'b1, 32'h0000_0500, 32'h0000_00BB);
        chk("ar_post_dat", cap_dat, 32'h0000_00BB);
        chk("ar_post_cyc", 32'(res_cyc), 32'd1);
        chk("ar_post_err", 32'(res_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Single-transaction Wishbone initiator that turns a simple command/response handshake into classic (non-pipelined) Wishbone read and write cycles on the conbus. It gives test firmware, debug bridges and small DMA-less engines one bus-master port without each implementing cycle timing. Every cycle is bounded by a timeout, so an unresponsive slave returns an error instead of hanging the master.

## Interface
- TIMEOUT, 255: maximum cycles `wb_stb_o` is held per transaction; legal range 1..65535.

- sys_clk  in  1  system clock; all logic on rising edge
- sys_rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  32  target byte address
- cmd_dat  in  32  write data (ignored on reads)
- rsp_valid  out  1  one-cycle pulse: transaction finished
- rsp_err  out  1  qualifies rsp_valid: 1 = timeout
- rsp_dat  out  32  read data; 0 for writes and on error
- wb_adr_o  out  32  Wishbone address
- wb_dat_o  out  32  Wishbone write data
- wb_dat_i  in  32  Wishbone read data
- wb_sel_o  out  4  byte selects, constant 4'hF
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe (always equal to wb_cyc_o)
- wb_we_o  out  1  write enable
- wb_ack_i  in  1  slave acknowledge

## Operation
- FSM states: IDLE, BUS, RESP. Reset state IDLE.
- IDLE: cmd_ready = 1. Accept on the edge where cmd_valid & cmd_ready: latch cmd_adr/cmd_dat/cmd_we into wb_adr_o/wb_dat_o/wb_we_o, set wb_cyc_o = wb_stb_o = 1, clear the timeout counter, go to BUS.
- BUS: cmd_ready = 0. Address, data, we stay stable for the whole cycle.
  - wb_ack_i sampled 1: drop cyc/stb, capture rsp_dat = wb_dat_i (read) or 0 (write), rsp_err = 0, go to RESP.
  - No ack and counter == TIMEOUT-1: drop cyc/stb, rsp_dat = 0, rsp_err = 1, go to RESP.
  - Otherwise counter += 1 (16-bit, never wraps because of the compare).
  - Ack on the same edge as timeout expiry: ack wins, success response.
- RESP: rsp_valid = 1 for exactly this one cycle. There is no response back-pressure. cmd_ready = 0. Next state is IDLE.
- rsp_dat/rsp_err hold their value until the next response. They are meaningful only while rsp_valid = 1.
- wb_ack_i outside BUS is ignored.
- All outputs are registered except cmd_ready, which decodes state == IDLE.

## Timing
- Reset values: wb_cyc_o = wb_stb_o = wb_we_o = 0, wb_adr_o = wb_dat_o = 0, rsp_valid = rsp_err = 0, rsp_dat = 0, cmd_ready = 1 once sys_rst deasserts. wb_sel_o is always 4'hF.
- Assertion of sys_rst at any point, including mid-BUS, immediately clears cyc/stb and the counter and returns to IDLE. No rsp_valid is produced for the aborted transaction.
- Edge naming: E0 is the accept edge. cyc/stb are high in the cycle after E0.
- Slave acking with W wait states: ack sampled at E0+1+W. rsp_valid is high in the cycle after that edge. cmd_ready returns 1 one cycle later.
  - Zero-wait slave: cyc high 1 cycle, rsp_valid 2 cycles after accept, next accept possible at E0+3.
- Timeout: stb is high for exactly TIMEOUT cycles.
- Back-to-back commands always leave at least 2 cycles with cyc = 0 between bus cycles (RESP and IDLE). This guarantees slaves that return through an idle state before re-sampling stb see it low.

## Test plan
- Zero-wait write: cmd_we = 1, adr 0x6000_0000, dat 0x0000_0001; slave acks combinationally on stb -> wb_we_o = 1 and wb_dat_o = 0x1 for 1 cycle, rsp_valid one cycle later, rsp_err = 0, rsp_dat = 0.
- 3-wait-state read: slave model IDLE→DELAY1→DELAY2→ACK drives 0xDEADBEEF with ack -> cyc high exactly 4 cycles, rsp_dat = 0xDEADBEEF, rsp_err = 0, single rsp_valid pulse.
- Timeout: TIMEOUT = 8, slave never acks -> stb high exactly 8 cycles, then rsp_valid with rsp_err = 1, rsp_dat = 0; cmd_ready = 1 one cycle later.
- Ack on final cycle: TIMEOUT = 8, ack asserted in the 8th stb cycle with data 0x1234_5678 -> rsp_err = 0, rsp_dat = 0x1234_5678.
- Back-to-back: cmd_valid held high with write 0xA then read -> second accept occurs the cycle cmd_ready returns, cyc low for exactly 2 cycles between transactions, two rsp_valid pulses in order.
- Reset mid-BUS: assert sys_rst asynchronously (between edges) during the 2nd stb cycle -> cyc/stb fall without waiting for a clock edge, no rsp_valid, cmd_ready = 1 after release, a following write completes normally.
